// File: rtl/vec_seq_pkg.sv
// Shared types and defaults for the vec_seq_chk stimulus sequencer / response checker.
package vec_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int VEC_W_DEF   = 4;
  localparam int NUM_VEC_DEF = 16;
  localparam int HOLD_DEF    = 3;
  localparam int ERR_W_DEF   = 8;

  // Expected E for v = {A,B,C,F}: (A&B&C) | (~A&~B) | F
  function automatic logic golden_exp(input logic [3:0] v);
    return (v[3] & v[2] & v[1]) | (~v[3] & ~v[2]) | v[0];
  endfunction

endpackage

// File: rtl/vec_seq_chk_hold_ctr.sv
// Per-vector hold counter: counts cycles while enabled and pulses adv on the
// last hold cycle, wrapping to 0 on the same edge.
module vec_seq_hold_ctr #(
  parameter int HOLD = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic adv
);

  localparam int CNT_W = (HOLD > 2) ? $clog2(HOLD) : 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;

  assign adv = en && (hold_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      hold_cnt <= '0;
    end else if (en) begin
      hold_cnt <= adv ? '0 : hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vec_seq_chk.sv
// Drives vectors 0..NUM_VEC-1 for HOLD cycles each and counts responses that differ
// from golden_exp. Optional first-error capture: VEC_SEQ_CHK_ERR_CAPTURE_EN.
// Handshake: vec_valid high means vec_out is run stimulus; there is no back-pressure.
module vec_seq_chk
  import vec_seq_pkg::*;
#(
  parameter int VEC_W   = VEC_W_DEF,
  parameter int NUM_VEC = NUM_VEC_DEF,
  parameter int HOLD    = HOLD_DEF,
  parameter int ERR_W   = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [VEC_W-1:0] vec_out,
  output logic             vec_valid,
  input  logic             resp_in,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             pass,
  output state_t           dbg_state
`ifdef VEC_SEQ_CHK_ERR_CAPTURE_EN
  ,
  output logic             first_err_vld,
  output logic [VEC_W-1:0] first_err_vec
`endif
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t state;
  logic   adv;
  logic   load;
  logic   mismatch;

  assign load      = start && (state != RUN);
  assign mismatch  = (resp_in != golden_exp(4'(vec_out)));
  assign pass      = done && (err_cnt == '0);
  assign dbg_state = state;

  vec_seq_hold_ctr #(.HOLD(HOLD)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (state == RUN),
    .adv  (adv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
`ifdef VEC_SEQ_CHK_ERR_CAPTURE_EN
      first_err_vld <= 1'b0;
      first_err_vec <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            vec_out   <= '0;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_cnt   <= '0;
`ifdef VEC_SEQ_CHK_ERR_CAPTURE_EN
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
`endif
          end
        end
        RUN: begin
          // Compare and advance share the last hold edge of each vector.
          if (adv) begin
            if (mismatch) begin
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
`ifdef VEC_SEQ_CHK_ERR_CAPTURE_EN
              if (!first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_vec <= vec_out;
              end
`endif
            end
            if (vec_out == LAST_VEC) begin
              state     <= DONE;
              busy      <= 1'b0;
              vec_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              vec_out <= vec_out + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_seq_chk.sv
// Bench for vec_seq_chk: default instance plus a HOLD=4 / ERR_W=2 instance, both
// checked every cycle against a cycle-index model of the run.
module tb_vec_seq_chk;
  import vec_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_i [2];
  int         mode    [2];   // 0 ideal, 1 stuck-1, 2 stuck-0, 3 random
  logic       resp    [2];
  logic       e_reg   [2];
  logic       rand_bit;

  logic [3:0] o_vec   [2];
  logic       o_valid [2];
  logic       o_busy  [2];
  logic       o_done  [2];
  logic       o_pass  [2];
  logic [7:0] o_err   [2];
  state_t     o_state [2];
  logic [7:0] err0;
  logic [1:0] err1;
`ifdef VEC_SEQ_CHK_ERR_CAPTURE_EN
  logic       o_fev [2];
  logic [3:0] o_fe  [2];
`endif

  assign o_err[0] = err0;
  assign o_err[1] = {6'b0, err1};

  vec_seq_chk dut (
    .clk(clk), .rst(rst), .start(start_i[0]), .vec_out(o_vec[0]), .vec_valid(o_valid[0]),
    .resp_in(resp[0]), .busy(o_busy[0]), .done(o_done[0]), .err_cnt(err0), .pass(o_pass[0]),
    .dbg_state(o_state[0])
`ifdef VEC_SEQ_CHK_ERR_CAPTURE_EN
    , .first_err_vld(o_fev[0]), .first_err_vec(o_fe[0])
`endif
  );

  vec_seq_chk #(.HOLD(4), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start_i[1]), .vec_out(o_vec[1]), .vec_valid(o_valid[1]),
    .resp_in(resp[1]), .busy(o_busy[1]), .done(o_done[1]), .err_cnt(err1), .pass(o_pass[1]),
    .dbg_state(o_state[1])
`ifdef VEC_SEQ_CHK_ERR_CAPTURE_EN
    , .first_err_vld(o_fev[1]), .first_err_vec(o_fe[1])
`endif
  );

  // Expected E per vector: zero only for 4, 6, 8, 10, 12.
  logic [15:0] gold_mask = 16'hEAAF;

  // Registered checked block (second stage) plus response source mux.
  always @(posedge clk) begin
    e_reg[0] <= gold_mask[o_vec[0]];
    e_reg[1] <= gold_mask[o_vec[1]];
  end
  always @(negedge clk) rand_bit = 1'($urandom_range(0, 1));
  for (genvar g = 0; g < 2; g++) begin : g_resp
    assign resp[g] = (mode[g] == 0) ? e_reg[g] :
                     (mode[g] == 1) ? 1'b1 :
                     (mode[g] == 2) ? 1'b0 : rand_bit;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is indexed by t = edges since the start edge. Vector k is compared
  // at t = HOLD*(k+1); the vector in flight is t/HOLD.
  int   hold_of [2] = '{3, 4};
  int   emax_of [2] = '{255, 3};
  bit   m_run   [2] = '{0, 0};
  bit   m_done  [2] = '{0, 0};
  int   m_t     [2] = '{0, 0};
  int   m_err   [2] = '{0, 0};
  int   m_vec   [2] = '{0, 0};
  bit   m_fev   [2] = '{0, 0};
  int   m_fe    [2] = '{0, 0};
  bit   seen_rst = 0;
  int   mk;

  always @(posedge clk) begin
    if (rst) seen_rst = 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] = 0; m_done[i] = 0; m_err[i] = 0; m_vec[i] = 0; m_fev[i] = 0; m_fe[i] = 0;
      end else if (!m_run[i] && start_i[i]) begin
        m_run[i] = 1; m_t[i] = 0; m_done[i] = 0; m_err[i] = 0; m_vec[i] = 0;
        m_fev[i] = 0; m_fe[i] = 0;
      end else if (m_run[i]) begin
        m_t[i]++;
        if (m_t[i] % hold_of[i] == 0) begin
          mk = m_t[i] / hold_of[i] - 1;
          if (resp[i] != gold_mask[mk]) begin
            if (m_err[i] < emax_of[i]) m_err[i]++;
            if (!m_fev[i]) begin m_fev[i] = 1; m_fe[i] = mk; end
          end
          if (mk == 15) begin m_run[i] = 0; m_done[i] = 1; m_vec[i] = 15; end
          else m_vec[i] = mk + 1;
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (seen_rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("vec_out[%0d]", i), int'(o_vec[i]), m_vec[i]);
        chk($sformatf("vec_valid[%0d]", i), int'(o_valid[i]), int'(m_run[i]));
        chk($sformatf("busy[%0d]", i), int'(o_busy[i]), int'(m_run[i]));
        chk($sformatf("done[%0d]", i), int'(o_done[i]), int'(m_done[i]));
        chk($sformatf("err_cnt[%0d]", i), int'(o_err[i]), m_err[i]);
        chk($sformatf("pass[%0d]", i), int'(o_pass[i]), int'(m_done[i] && m_err[i] == 0));
        chk($sformatf("state[%0d]", i), int'(o_state[i]),
            m_run[i] ? int'(RUN) : (m_done[i] ? int'(DONE) : int'(IDLE)));
`ifdef VEC_SEQ_CHK_ERR_CAPTURE_EN
        chk($sformatf("first_err_vld[%0d]", i), int'(o_fev[i]), int'(m_fev[i]));
        chk($sformatf("first_err_vec[%0d]", i), int'(o_fe[i]), m_fe[i]);
`endif
      end
    end
  end

  // Start a run and return edges from the start edge until done is seen.
  // Extra start pulses are issued at edge offsets p1/p2 (0 = none).
  task automatic run_timed(input int i, input int p1, input int p2, output int n);
    @(negedge clk);
    start_i[i] = 1'b1;
    @(posedge clk);
    #1;
    chk("start_edge_done_low", int'(o_done[i]), 0);
    chk("start_edge_vec_zero", int'(o_vec[i]), 0);
    chk("start_edge_err_zero", int'(o_err[i]), 0);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      start_i[i] = ((n + 1) == p1 || (n + 1) == p2) ? 1'b1 : 1'b0;
      @(posedge clk);
      n++;
      #1;
      if (o_done[i]) break;
    end
    @(negedge clk);
    start_i[i] = 1'b0;
    chk("done_seen", int'(o_done[i]), 1);
  endtask

  task automatic start_then_reset(input int i, input int at_edge);
    @(negedge clk);
    start_i[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i[i] = 1'b0;
    repeat (at_edge - 1) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_vec_out", int'(o_vec[i]), 0);
    chk("rst_busy", int'(o_busy[i]), 0);
    chk("rst_err_cnt", int'(o_err[i]), 0);
    chk("rst_state", int'(o_state[i]), int'(IDLE));
    @(negedge clk);
    rst = 1'b0;
  endtask

  int n;

  initial begin
    start_i[0] = 1'b0; start_i[1] = 1'b0;
    mode[0] = 0; mode[1] = 2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", int'(o_done[0]), 0);
    chk("reset_valid", int'(o_valid[0]), 0);
    @(negedge clk);
    rst = 1'b0;

    // Ideal response
    run_timed(0, 0, 0, n);
    chk("ideal_latency", n, 48);
    chk("ideal_err", int'(o_err[0]), 0);
    chk("ideal_pass", int'(o_pass[0]), 1);

    // Stuck-at-1 and stuck-at-0
    mode[0] = 1;
    run_timed(0, 0, 0, n);
    chk("stuck1_err", int'(o_err[0]), 5);
    chk("stuck1_pass", int'(o_pass[0]), 0);
`ifdef VEC_SEQ_CHK_ERR_CAPTURE_EN
    chk("stuck1_first_vec", int'(o_fe[0]), 4);
`endif
    mode[0] = 2;
    run_timed(0, 0, 0, n);
    chk("stuck0_err", int'(o_err[0]), 11);
`ifdef VEC_SEQ_CHK_ERR_CAPTURE_EN
    chk("stuck0_first_vec", int'(o_fe[0]), 0);
`endif

    // Reset at edge 20, then a clean run
    mode[0] = 0;
    start_then_reset(0, 20);
    run_timed(0, 0, 0, n);
    chk("post_rst_latency", n, 48);
    chk("post_rst_err", int'(o_err[0]), 0);

    // Start pulses during RUN are ignored; start in DONE restarts
    mode[0] = 1;
    run_timed(0, 5, 30, n);
    chk("start_in_run_latency", n, 48);
    run_timed(0, 0, 0, n);
    chk("restart_from_done_err", int'(o_err[0]), 5);

    // Saturation instance: HOLD=4, ERR_W=2, stuck-at-0
    run_timed(1, 0, 0, n);
    chk("sat_latency", n, 64);
    chk("sat_err", int'(o_err[1]), 3);

    // Randomized responses, stray starts and mid-run resets
    mode[0] = 3; mode[1] = 3;
    for (int r = 0; r < 4; r++) begin
      run_timed(0, $urandom_range(1, 47), $urandom_range(1, 47), n);
      chk("rand_latency", n, 48);
      if (r == 1) start_then_reset(0, $urandom_range(2, 47));
    end
    run_timed(1, $urandom_range(1, 63), 0, n);
    chk("rand_sat_latency", n, 64);

    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
